scr_base_l3_bk_rsp_collect: RTL and testbench

//  Response-side counterpart of the L3 bank ROB. Receives inbound responses (SnpResp from RN-F,

---
 rtl/scr_base_l3_bk_rsp_collect_if.sv | 14 +
 rtl/scr_base_l3_bk_rsp_collect.sv | 127 ++++++++++++
 tb/tb_scr_base_l3_bk_rsp_collect.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/scr_base_l3_bk_rsp_collect_if.sv
// scr_base_l3_bk_rsp_collect_if: inbound response channel (valid/ready plus payload)
interface scr_base_l3_bk_rsp_collect_if #(
  parameter int TXNID_W = 8,
  parameter int DBID_W  = 8
);
  logic               rsp_in_val_i;
  logic               rsp_in_ready_o;
  logic [1:0]         rsp_in_opc_i;
  logic [TXNID_W-1:0] rsp_in_txnid_i;
  logic [DBID_W-1:0]  rsp_in_dbid_i;
  logic               rsp_in_dirty_i;
  modport master (output rsp_in_val_i, rsp_in_opc_i, rsp_in_txnid_i, rsp_in_dbid_i, rsp_in_dirty_i, input rsp_in_ready_o);
  modport slave  (input rsp_in_val_i, rsp_in_opc_i, rsp_in_txnid_i, rsp_in_dbid_i, rsp_in_dirty_i, output rsp_in_ready_o);
endinterface

// File: rtl/scr_base_l3_bk_rsp_collect.sv
// scr_base_l3_bk_rsp_collect: per-ROB-cell collection of SnpResp/CompAck/CompDBIDResp
module scr_base_l3_bk_rsp_collect #(
  parameter int ROB_DEPTH = 16,
  parameter int PTR_SIZE  = 4,
  parameter int SNP_CNT_W = 4,
  parameter int TXNID_W   = 8,
  parameter int DBID_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alloc_val_i,
  input  logic [PTR_SIZE-1:0]         alloc_cell_i,
  input  logic [SNP_CNT_W-1:0]        alloc_snp_cnt_i,
  input  logic                        alloc_need_ack_i,
  input  logic                        alloc_need_dbid_i,
  input  logic                        rel_val_i,
  input  logic [PTR_SIZE-1:0]         rel_cell_i,
  scr_base_l3_bk_rsp_collect_if.slave rsp,
  output logic [ROB_DEPTH-1:0]        snp_ack_collected_vect_o,
  output logic [ROB_DEPTH-1:0]        comp_ack_collected_vect_o,
  output logic [ROB_DEPTH-1:0]        comp_dbid_collected_vect_o,
  output logic [ROB_DEPTH-1:0]        snp_dirty_vect_o,
  output logic [ROB_DEPTH*DBID_W-1:0] cell_dbid_o,
  output logic                        err_val_o,
  output logic [PTR_SIZE-1:0]         err_cell_o
);
  logic                 r_ready, r1_val, r1_dirty, r_err_val;
  logic [1:0]           r1_opc;
  logic [TXNID_W-1:0]   r1_txnid;
  logic [DBID_W-1:0]    r1_dbid;
  logic [PTR_SIZE-1:0]  r_err_cell, w_idx;
  logic [ROB_DEPTH-1:0] r_act, r_ack, r_dbp, r_dirty, w_act, w_ack, w_dbp, w_dirty;
  logic [SNP_CNT_W-1:0] r_rem [ROB_DEPTH];
  logic [SNP_CNT_W-1:0] w_rem [ROB_DEPTH];
  logic [DBID_W-1:0]    r_dbid [ROB_DEPTH];
  logic [DBID_W-1:0]    w_dbid [ROB_DEPTH];
  logic                 w_oor, w_rel, w_relhit, w_bad, w_hit, w_err;
  assign rsp.rsp_in_ready_o = r_ready;
  // Next cell state: alloc first, then the R1 response against it, then an effective release
  always_comb begin
    w_idx    = r1_txnid[PTR_SIZE-1:0];
    w_oor    = (r1_txnid >> PTR_SIZE) != '0;
    w_rel    = rel_val_i & !(alloc_val_i & alloc_cell_i == rel_cell_i);
    w_relhit = w_rel & rel_cell_i == w_idx;
    w_act    = r_act;
    w_ack    = r_ack;
    w_dbp    = r_dbp;
    w_dirty  = r_dirty;
    w_rem    = r_rem;
    w_dbid   = r_dbid;
    if (alloc_val_i) begin
      w_act[alloc_cell_i]   = 1'b1;
      w_rem[alloc_cell_i]   = alloc_snp_cnt_i;
      w_ack[alloc_cell_i]   = alloc_need_ack_i;
      w_dbp[alloc_cell_i]   = alloc_need_dbid_i;
      w_dirty[alloc_cell_i] = 1'b0;
      w_dbid[alloc_cell_i]  = '0;
    end
    w_bad = r1_opc == 2'd3 | !w_act[w_idx] | (r1_opc == 2'd0 & w_rem[w_idx] == '0) |
            (r1_opc == 2'd1 & !w_ack[w_idx]) | (r1_opc == 2'd2 & !w_dbp[w_idx]);
    w_hit = r1_val & !w_oor & !w_relhit & !w_bad;
    w_err = r1_val & (w_oor | (!w_relhit & w_bad));
    if (w_hit) begin
      w_rem[w_idx]   = w_rem[w_idx] - SNP_CNT_W'(r1_opc == 2'd0);
      w_dirty[w_idx] = w_dirty[w_idx] | (r1_opc == 2'd0 & r1_dirty);
      w_ack[w_idx]   = w_ack[w_idx] & !(r1_opc == 2'd1);
      w_dbp[w_idx]   = w_dbp[w_idx] & !(r1_opc == 2'd2);
      w_dbid[w_idx]  = r1_opc == 2'd2 ? r1_dbid : w_dbid[w_idx];
    end
    if (w_rel) begin
      w_act[rel_cell_i]   = 1'b0;
      w_rem[rel_cell_i]   = '0;
      w_ack[rel_cell_i]   = 1'b0;
      w_dbp[rel_cell_i]   = 1'b0;
      w_dirty[rel_cell_i] = 1'b0;
      w_dbid[rel_cell_i]  = '0;
    end
  end
  // R1 capture, cell state and error pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready    <= 1'b0;
      r1_val     <= 1'b0;
      r1_opc     <= '0;
      r1_txnid   <= '0;
      r1_dbid    <= '0;
      r1_dirty   <= 1'b0;
      r_act      <= '0;
      r_ack      <= '0;
      r_dbp      <= '0;
      r_dirty    <= '0;
      r_rem      <= '{default: '0};
      r_dbid     <= '{default: '0};
      r_err_val  <= 1'b0;
      r_err_cell <= '0;
    end else begin
      r_ready    <= 1'b1;
      r1_val     <= rsp.rsp_in_val_i & r_ready;
      r1_opc     <= rsp.rsp_in_opc_i;
      r1_txnid   <= rsp.rsp_in_txnid_i;
      r1_dbid    <= rsp.rsp_in_dbid_i;
      r1_dirty   <= rsp.rsp_in_dirty_i;
      r_act      <= w_act;
      r_ack      <= w_ack;
      r_dbp      <= w_dbp;
      r_dirty    <= w_dirty;
      r_rem      <= w_rem;
      r_dbid     <= w_dbid;
      r_err_val  <= w_err;
      r_err_cell <= w_idx;
    end
  end
  // Collected vectors and flattened DBIDs derived from cell state
  always_comb begin
    snp_ack_collected_vect_o   = '0;
    cell_dbid_o                = '0;
    comp_ack_collected_vect_o  = r_act & ~r_ack;
    comp_dbid_collected_vect_o = r_act & ~r_dbp;
    snp_dirty_vect_o           = r_dirty;
    for (int i = 0; i < ROB_DEPTH; i++) begin
      snp_ack_collected_vect_o[i]   = r_act[i] & r_rem[i] == '0;
      cell_dbid_o[i*DBID_W +: DBID_W] = r_dbid[i];
    end
  end
  assign err_val_o  = r_err_val;
  assign err_cell_o = r_err_cell;
endmodule

// File: tb/tb_scr_base_l3_bk_rsp_collect.sv
// tb_scr_base_l3_bk_rsp_collect: event-ordered cell model plus directed literal checks
module tb_scr_base_l3_bk_rsp_collect;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic        alloc_val, alloc_ack, alloc_dbid, rel_val;
  logic [3:0]  alloc_cell, alloc_cnt, rel_cell, err_c;
  logic [15:0] snp_v, ca_v, cd_v, dt_v;
  logic [127:0] dbid_v;
  logic        err_v;
  scr_base_l3_bk_rsp_collect_if #(.TXNID_W(8), .DBID_W(8)) rif ();
  scr_base_l3_bk_rsp_collect dut (
    .clk(clk), .rst(rst),
    .alloc_val_i(alloc_val), .alloc_cell_i(alloc_cell), .alloc_snp_cnt_i(alloc_cnt),
    .alloc_need_ack_i(alloc_ack), .alloc_need_dbid_i(alloc_dbid),
    .rel_val_i(rel_val), .rel_cell_i(rel_cell), .rsp(rif),
    .snp_ack_collected_vect_o(snp_v), .comp_ack_collected_vect_o(ca_v),
    .comp_dbid_collected_vect_o(cd_v), .snp_dirty_vect_o(dt_v), .cell_dbid_o(dbid_v),
    .err_val_o(err_v), .err_cell_o(err_c)
  );
  int total = 0, bad = 0;
  bit m_act[16], m_ack[16], m_dbp[16], m_dirty[16];
  int m_rem[16], m_dbid[16];
  bit m_ready, m_err, p_val, p_dirty, acc, ok;
  int m_ecell, p_op, p_tx, p_db, c;
  logic [15:0]  e_snp, e_ca, e_cd, e_dt;
  logic [127:0] e_dbid;
  logic [15:0]  save_v;
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask
  task automatic clr(input int k);
    m_act[k] = 0; m_rem[k] = 0; m_ack[k] = 0; m_dbp[k] = 0; m_dirty[k] = 0; m_dbid[k] = 0;
  endtask
  // model: events of one edge in order alloc, pending response, release
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) clr(k);
      m_ready = 0; m_err = 0; p_val = 0;
    end else begin
      acc = rif.rsp_in_val_i && m_ready;
      if (alloc_val) begin
        m_act[alloc_cell] = 1; m_rem[alloc_cell] = int'(alloc_cnt);
        m_ack[alloc_cell] = alloc_ack; m_dbp[alloc_cell] = alloc_dbid;
        m_dirty[alloc_cell] = 0; m_dbid[alloc_cell] = 0;
      end
      m_err = 0;
      if (p_val) begin
        c = p_tx % 16;
        if (p_tx >= 16) begin
          m_err = 1; m_ecell = c;
        end else if (!(rel_val && int'(rel_cell) == c && !(alloc_val && alloc_cell == rel_cell))) begin
          ok = m_act[c] && ((p_op == 0 && m_rem[c] > 0) || (p_op == 1 && m_ack[c]) || (p_op == 2 && m_dbp[c]));
          if (!ok) begin
            m_err = 1; m_ecell = c;
          end else if (p_op == 0) begin
            m_rem[c]--; m_dirty[c] |= p_dirty;
          end else if (p_op == 1) m_ack[c] = 0;
          else begin
            m_dbp[c] = 0; m_dbid[c] = p_db;
          end
        end
      end
      if (rel_val && !(alloc_val && alloc_cell == rel_cell)) clr(int'(rel_cell));
      p_val = acc; p_op = int'(rif.rsp_in_opc_i); p_tx = int'(rif.rsp_in_txnid_i);
      p_db = int'(rif.rsp_in_dbid_i); p_dirty = rif.rsp_in_dirty_i;
      m_ready = 1;
    end
  end
  // compare every cycle on the falling edge
  always @(negedge clk) begin
    for (int i = 0; i < 16; i++) begin
      e_snp[i] = m_act[i] && m_rem[i] == 0;
      e_ca[i]  = m_act[i] && !m_ack[i];
      e_cd[i]  = m_act[i] && !m_dbp[i];
      e_dt[i]  = m_dirty[i];
      e_dbid[i*8 +: 8] = m_dbid[i][7:0];
    end
    chk("m_ready", rif.rsp_in_ready_o, m_ready);
    chk("m_snp", snp_v, e_snp);
    chk("m_comp_ack", ca_v, e_ca);
    chk("m_comp_dbid", cd_v, e_cd);
    chk("m_dirty", dt_v, e_dt);
    chk("m_dbid", dbid_v, e_dbid);
    chk("m_err", err_v, m_err);
    if (m_err) chk("m_err_cell", err_c, m_ecell);
  end
  task automatic cyc; @(posedge clk); #1; endtask
  task automatic idle;
    alloc_val = 0; alloc_cell = 0; alloc_cnt = 0; alloc_ack = 0; alloc_dbid = 0;
    rel_val = 0; rel_cell = 0;
    rif.rsp_in_val_i = 0; rif.rsp_in_opc_i = 0; rif.rsp_in_txnid_i = 0;
    rif.rsp_in_dbid_i = 0; rif.rsp_in_dirty_i = 0;
  endtask
  task automatic alloc(input int cl, input int cnt, input bit a, input bit d);
    alloc_val = 1; alloc_cell = 4'(cl); alloc_cnt = 4'(cnt); alloc_ack = a; alloc_dbid = d;
  endtask
  task automatic rel(input int cl);
    rel_val = 1; rel_cell = 4'(cl);
  endtask
  task automatic rsp(input int op, input int tx, input int db, input bit dt);
    rif.rsp_in_val_i = 1; rif.rsp_in_opc_i = 2'(op); rif.rsp_in_txnid_i = 8'(tx);
    rif.rsp_in_dbid_i = 8'(db); rif.rsp_in_dirty_i = dt;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    idle;
    rsp(0, 1, 0, 0);
    repeat (3) cyc;
    chk("rst_ready", rif.rsp_in_ready_o, 0);
    chk("rst_snp", snp_v, 0);
    chk("rst_err", err_v, 0);
    idle; rst = 0;
    cyc;
    chk("ready_after_rst", rif.rsp_in_ready_o, 1);
    // 1: two snoops, dirty on the second
    alloc(3, 2, 0, 0); cyc; idle;
    rsp(0, 3, 0, 0); cyc;
    rsp(0, 3, 0, 1); cyc; idle;
    chk("t1_snp_mid", snp_v[3], 0);
    cyc;
    chk("t1_snp_done", snp_v[3], 1);
    chk("t1_dirty", dt_v[3], 1);
    chk("t1_ca", ca_v[3], 1);
    chk("t1_cd", cd_v[3], 1);
    // 2: DBID capture then release
    alloc(5, 0, 0, 1); cyc; idle;
    chk("t2_zero_snp", snp_v[5], 1);
    chk("t2_cd_armed", cd_v[5], 0);
    rsp(2, 5, 'hA7, 0); cyc; idle;
    chk("t2_cd_r1", cd_v[5], 0);
    cyc;
    chk("t2_cd_done", cd_v[5], 1);
    chk("t2_dbid", dbid_v[5*8 +: 8], 8'hA7);
    rel(5); cyc; idle;
    chk("t2_rel_cd", cd_v[5], 0);
    chk("t2_rel_dbid", dbid_v[5*8 +: 8], 0);
    // 3: errors on inactive cell and snoop underflow
    save_v = snp_v;
    rsp(1, 9, 0, 0); cyc;
    rsp(0, 3, 0, 0); cyc; idle;
    chk("t3_err9", err_v, 1);
    chk("t3_cell9", err_c, 9);
    cyc;
    chk("t3_err3", err_v, 1);
    chk("t3_cell3", err_c, 3);
    chk("t3_snp_same", snp_v, save_v);
    cyc;
    chk("t3_err_gone", err_v, 0);
    // 4: release beats R1, alloc precedes R1
    alloc(2, 0, 1, 0); cyc; idle;
    chk("t4_ca_armed", ca_v[2], 0);
    rsp(1, 2, 0, 0); cyc; idle;
    rel(2); cyc; idle;
    chk("t4_ca_rel", ca_v[2], 0);
    cyc;
    chk("t4_no_err", err_v, 0);
    rsp(0, 4, 0, 0); cyc; idle;
    alloc(4, 1, 0, 0); cyc; idle;
    chk("t4_snp4", snp_v[4], 1);
    cyc;
    chk("t4_no_err2", err_v, 0);
    // 5: streaming traffic with a reset in the middle
    for (int i = 0; i < 80; i++) begin
      idle;
      rst = (i >= 50 && i < 53);
      alloc($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0) rel($urandom_range(0, 15));
      rsp($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2),
          $urandom_range(0, 9) == 0 ? 'h20 + $urandom_range(0, 15) : $urandom_range(0, 15),
          $urandom_range(0, 255), $urandom_range(0, 1) == 1);
      cyc;
      if (rst) begin
        chk("t5_rst_ready", rif.rsp_in_ready_o, 0);
        chk("t5_rst_vec", {snp_v, ca_v, cd_v, dt_v}, 0);
      end
    end
    rst = 0; idle;
    repeat (3) cyc;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
